// File: rtl/fp_pkg.sv
// Shared types and helpers for the sequential floating-point adder.
package fp_pkg;

  // Guard, round and sticky bits carried below the mantissa LSB.
  localparam int GRS_W = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    ROUND = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Field extraction on a word zero-extended to 64 bits; widths are runtime arguments
  // so one set of helpers serves every EXP_W/MAN_W combination.
  function automatic logic get_sign(input logic [63:0] w, input int exp_w, input int man_w);
    logic [63:0] t;
    t = w >> (exp_w + man_w);
    return t[0];
  endfunction

  function automatic logic [31:0] get_exp(input logic [63:0] w, input int exp_w, input int man_w);
    logic [63:0] t;
    t = (w >> man_w) & ((64'd1 << exp_w) - 64'd1);
    return t[31:0];
  endfunction

  function automatic logic [63:0] get_man(input logic [63:0] w, input int man_w);
    return w & ((64'd1 << man_w) - 64'd1);
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input returns WIDTH.
module fp_lzc #(
  parameter int WIDTH = 27
) (
  input  logic [WIDTH-1:0]               d,
  output logic [$clog2(WIDTH+1)-1:0]     cnt
);

  localparam int CW = $clog2(WIDTH + 1);

  // Scan upward so the highest set bit determines the final count.
  always_comb begin
    cnt = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (d[i]) cnt = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/sumador_flotante_seq.sv
// Multi-cycle floating-point adder/subtractor, round-to-nearest-even.
// Handshake: a transfer happens on a rising edge where valid && ready. in_ready is high
// only in IDLE; out_valid stays high with s/flags frozen until out_ready is seen.
module sumador_flotante_seq
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [EXP_W+MAN_W:0]       a,
  input  logic [EXP_W+MAN_W:0]       b,
  input  logic                       op,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [EXP_W+MAN_W:0]       s,
  output logic                       overflow,
  output logic                       zero,
  output state_t                     state_dbg
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int MW   = MAN_W + 1 + GRS_W;   // {hidden, man, G, R, S}
  localparam int LZ_W = $clog2(MW + 1);
  localparam int EW   = EXP_W + 2;           // room for carry and underflow sign

  state_t            state;
  logic [W-1:0]      a_r, b_r;
  logic              op_r;
  // ALIGN -> ADD
  logic              x_sign, eff_sub;
  logic [EXP_W-1:0]  x_exp;
  logic [MW-1:0]     x_sig, y_sig;
  // ADD -> NORM
  logic [MW:0]       sum_r;
  // NORM -> ROUND
  logic              n_sign, n_zero;
  logic [EW-1:0]     n_exp;
  logic [MW-1:0]     n_man;

  // Combinational next values for each stage
  logic              al_sign, al_sub;
  logic [EXP_W-1:0]  al_exp;
  logic [MW-1:0]     al_x, al_y;
  logic [MW:0]       sum_nx;
  logic              nm_sign, nm_zero;
  logic [EW-1:0]     nm_exp;
  logic [MW-1:0]     nm_man;
  logic [W-1:0]      rd_s;
  logic              rd_ovf, rd_zero;
  logic [LZ_W-1:0]   lz;

  fp_lzc #(.WIDTH(MW)) u_lzc (
    .d   (sum_r[MW-1:0]),
    .cnt (lz)
  );

  assign state_dbg = state;

  // Per-stage datapath: alignment, add/subtract, normalisation and rounding.
  always_comb begin
    logic              sa, sb;
    logic [EXP_W-1:0]  ea, eb, ey, diff;
    logic [MAN_W-1:0]  ma, mb, mx, my;
    logic              swap, lost;
    logic [MW-1:0]     sig_y, shifted;
    logic [MAN_W:0]    mant;
    logic [MAN_W+1:0]  rnd;
    logic [EW-1:0]     rexp;
    logic [MAN_W-1:0]  frac;
    logic              inc;

    // ALIGN: exp==0 operands are zero, larger magnitude becomes X
    sa = get_sign(64'(a_r), EXP_W, MAN_W);
    sb = get_sign(64'(b_r), EXP_W, MAN_W) ^ op_r;
    ea = EXP_W'(get_exp(64'(a_r), EXP_W, MAN_W));
    eb = EXP_W'(get_exp(64'(b_r), EXP_W, MAN_W));
    ma = (ea == '0) ? '0 : MAN_W'(get_man(64'(a_r), MAN_W));
    mb = (eb == '0) ? '0 : MAN_W'(get_man(64'(b_r), MAN_W));
    swap    = {eb, mb} > {ea, ma};
    al_sign = swap ? sb : sa;
    al_sub  = sa ^ sb;
    al_exp  = swap ? eb : ea;
    ey      = swap ? ea : eb;
    mx      = swap ? mb : ma;
    my      = swap ? ma : mb;
    diff    = al_exp - ey;
    al_x    = {al_exp != '0, mx, {GRS_W{1'b0}}};
    sig_y   = {ey != '0, my, {GRS_W{1'b0}}};
    if (int'(diff) >= MW) begin
      shifted = {{(MW-1){1'b0}}, |sig_y};
      lost    = 1'b0;
    end else begin
      shifted = sig_y >> diff;
      lost    = |(sig_y & ~({MW{1'b1}} << diff));
    end
    al_y = {shifted[MW-1:1], shifted[0] | lost};

    // ADD: the swap guarantees X >= Y, so the difference never goes negative
    sum_nx = eff_sub ? ({1'b0, x_sig} - {1'b0, y_sig}) : ({1'b0, x_sig} + {1'b0, y_sig});

    // NORM: carry shifts right, otherwise shift left by the leading-zero count
    nm_sign = x_sign;
    nm_zero = 1'b0;
    nm_exp  = '0;
    nm_man  = '0;
    if (sum_r[MW]) begin
      nm_man = {sum_r[MW:2], sum_r[1] | sum_r[0]};
      nm_exp = EW'(x_exp) + EW'(1);
    end else if (sum_r == '0) begin
      nm_sign = 1'b0;
      nm_zero = 1'b1;
    end else begin
      nm_man = sum_r[MW-1:0] << lz;
      nm_exp = EW'(x_exp) - EW'(lz);
      if (nm_exp[EW-1] || nm_exp == '0) begin
        nm_zero = 1'b1;
        nm_exp  = '0;
        nm_man  = '0;
      end
    end

    // ROUND: nearest-even, renormalise on mantissa carry, saturate on overflow
    mant = n_man[MW-1:GRS_W];
    inc  = n_man[2] & (n_man[1] | n_man[0] | mant[0]);
    rnd  = {1'b0, mant} + (MAN_W+2)'(inc);
    rexp = n_exp + EW'(rnd[MAN_W+1]);
    frac = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
    rd_zero = n_zero;
    rd_ovf  = 1'b0;
    if (n_zero) begin
      rd_s = {n_sign, {(W-1){1'b0}}};
    end else if (rexp >= EW'((1 << EXP_W) - 1)) begin
      rd_ovf = 1'b1;
      rd_s   = {n_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else begin
      rd_s = {n_sign, rexp[EXP_W-1:0], frac};
    end
  end

  // Sequencer plus all pipeline, handshake and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      s         <= '0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      op_r      <= 1'b0;
      x_sign    <= 1'b0;
      eff_sub   <= 1'b0;
      x_exp     <= '0;
      x_sig     <= '0;
      y_sig     <= '0;
      sum_r     <= '0;
      n_sign    <= 1'b0;
      n_zero    <= 1'b0;
      n_exp     <= '0;
      n_man     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            op_r     <= op;
            in_ready <= 1'b0;
            state    <= ALIGN;
          end
        end
        ALIGN: begin
          x_sign  <= al_sign;
          eff_sub <= al_sub;
          x_exp   <= al_exp;
          x_sig   <= al_x;
          y_sig   <= al_y;
          state   <= ADD;
        end
        ADD: begin
          sum_r <= sum_nx;
          state <= NORM;
        end
        NORM: begin
          n_sign <= nm_sign;
          n_zero <= nm_zero;
          n_exp  <= nm_exp;
          n_man  <= nm_man;
          state  <= ROUND;
        end
        ROUND: begin
          s         <= rd_s;
          overflow  <= rd_ovf;
          zero      <= rd_zero;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
